// File: rtl/rr_ffo_arbiter_pkg.sv
// Shared types and constants for the round-robin find-first-one arbiter.
package rr_ffo_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_IW_MAX = 6;

  // All-ones ffo result; truncated to the instance index width it means "no requester".
  localparam logic [ARB_IW_MAX-1:0] ARB_NONE = '1;

  function automatic int unsigned arb_iw(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_ffo_arbiter_ffo.sv
// Find-first-one from the top: index of the highest set bit, all-ones when the input is zero.
module rr_ffo_arbiter_ffo #(
  parameter int unsigned N  = 12,
  parameter int unsigned IW = 4
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx_o = '1;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/rr_ffo_arbiter.sv
// Round-robin arbiter: masked/unmasked ffo selection, sticky valid/ready grant,
// resource lock until done, and a BUSY-cycle watchdog.
module rr_ffo_arbiter
  import rr_ffo_arbiter_pkg::*;
#(
  parameter  int unsigned N   = 12,
  parameter  int unsigned TMO = 255,
  localparam int unsigned IW  = arb_iw(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          gnt_rdy_i,
  input  logic          done_i,
  output logic          gnt_v_o,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          busy_o,
  output logic          tmo_o
);

  localparam int unsigned CW = (TMO == 0) ? 1 : $clog2(TMO + 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_v_q, gnt_v_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          tmo_q, tmo_d;

  logic [N-1:0]  mask_c;
  logic [N-1:0]  masked_c;
  logic [IW-1:0] ffo_masked_c;
  logic [IW-1:0] ffo_full_c;
  logic [IW-1:0] sel_c;
  logic          rel_c;

  // Requesters below the last released owner get first pick.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < N; i++) begin
      mask_c[i] = (IW'(i) < last_q);
    end
    masked_c = req_i & mask_c;
    sel_c    = (ffo_masked_c == ARB_NONE[IW-1:0]) ? ffo_full_c : ffo_masked_c;
  end

  rr_ffo_arbiter_ffo #(.N(N), .IW(IW)) u_ffo_masked (
    .vec_i (masked_c),
    .idx_o (ffo_masked_c)
  );

  rr_ffo_arbiter_ffo #(.N(N), .IW(IW)) u_ffo_full (
    .vec_i (req_i),
    .idx_o (ffo_full_c)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_v_d = gnt_v_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    rel_c   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (|req_i) begin
          state_d = ARB_GRANT;
          gnt_v_d = 1'b1;
          idx_d   = sel_c;
          gnt_d   = N'(1) << sel_c;
        end
      end
      ARB_GRANT: begin
        if (gnt_rdy_i) begin
          if (done_i) begin
            rel_c = 1'b1;
          end else begin
            state_d = ARB_BUSY;
            gnt_v_d = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      ARB_BUSY: begin
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        // A done on the timeout cycle is a normal release.
        if (done_i) begin
          rel_c = 1'b1;
        end else if ((TMO != 0) && (cnt_q == CW'(TMO - 1))) begin
          rel_c = 1'b1;
          tmo_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (rel_c) begin
      state_d = ARB_IDLE;
      last_d  = idx_q;
      gnt_v_d = 1'b0;
      busy_d  = 1'b0;
      gnt_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= '0;
      cnt_q   <= '0;
      gnt_v_q <= 1'b0;
      gnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_v_q <= gnt_v_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt_v_o   = gnt_v_q;
  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign busy_o    = busy_q;
  assign tmo_o     = tmo_q;

endmodule

// File: tb/tb_rr_ffo_arbiter.sv
// Bench for rr_ffo_arbiter: directed scenarios plus randomized transactions
// against a rotating-priority reference model.
module tb_rr_ffo_arbiter;

  localparam int unsigned N    = 12;
  localparam int unsigned TW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          rdy;
  logic          done;

  logic          gnt_v, busy, tmo;
  logic [N-1:0]  gnt;
  logic [3:0]    idx;
  logic          w_gnt_v, w_busy, w_tmo;
  logic [N-1:0]  w_gnt;
  logic [3:0]    w_idx;

  logic [18:0]   o_m, o_w;
  assign o_m = {gnt_v, busy, tmo, gnt, idx};
  assign o_w = {w_gnt_v, w_busy, w_tmo, w_gnt, w_idx};

  int checks = 0;
  int errors = 0;
  int m_last = 0;

  always #5 clk = ~clk;

  rr_ffo_arbiter #(.N(N), .TMO(255)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_rdy_i(rdy), .done_i(done),
    .gnt_v_o(gnt_v), .gnt_o(gnt), .gnt_idx_o(idx), .busy_o(busy), .tmo_o(tmo)
  );

  rr_ffo_arbiter #(.N(N), .TMO(TW)) dut_w (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_rdy_i(rdy), .done_i(done),
    .gnt_v_o(w_gnt_v), .gnt_o(w_gnt), .gnt_idx_o(w_idx), .busy_o(w_busy), .tmo_o(w_tmo)
  );

  // Rotating priority: start just below last, wrap to N-1, finish at last.
  function automatic int pick(input logic [N-1:0] r, input int last);
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (last - k + N) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Expected {gnt_v, busy, tmo, gnt, idx}; i < 0 means no owner.
  function automatic logic [18:0] ex(input logic v, input logic b, input logic t, input int i);
    logic [N-1:0] g;
    logic [3:0]   x;
    g = '0;
    x = '0;
    if (i >= 0) begin
      g[i] = 1'b1;
      x    = 4'(i);
    end
    return {v, b, t, g, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rdy = 1'b0; done = 1'b0;
    tick();
    rst = 1'b0;
    m_last = 0;
  endtask

  task automatic test_reset();
    logic [18:0] e;
    rst = 1'b1; req = 12'h841; rdy = 1'b0; done = 1'b0;
    tick();
    checks++; if (o_m !== 19'h0) begin errors++; $display("FAIL reset_m: got %h exp %h", o_m, 19'h0); end
    checks++; if (o_w !== 19'h0) begin errors++; $display("FAIL reset_w: got %h exp %h", o_w, 19'h0); end
    rst = 1'b0;
    m_last = 0;
    tick();
    e = ex(1'b1, 1'b0, 1'b0, pick(req, m_last));
    checks++; if (o_m !== e) begin errors++; $display("FAIL first_grant: got %h exp %h", o_m, e); end
    checks++; if (idx !== 4'd11 || gnt !== 12'h800) begin errors++; $display("FAIL first_idx: got %0d/%h exp 11/800", idx, gnt); end
  endtask

  task automatic test_rotation();
    logic [18:0] e;
    int cur;
    int seen [4];
    cur = 11;
    rdy = 1'b1; done = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      m_last = cur;
      e = ex(1'b0, 1'b0, 1'b0, -1);
      checks++; if (o_m !== e) begin errors++; $display("FAIL rot_dead%0d: got %h exp %h", g, o_m, e); end
      tick();
      cur = pick(req, m_last);
      seen[g] = int'(idx);
      e = ex(1'b1, 1'b0, 1'b0, cur);
      checks++; if (o_m !== e) begin errors++; $display("FAIL rot_grant%0d: got %h exp %h", g, o_m, e); end
    end
    checks++;
    if (seen[0] != 6 || seen[1] != 0 || seen[2] != 11 || seen[3] != 6) begin
      errors++; $display("FAIL rot_order: got %0d %0d %0d %0d exp 6 0 11 6", seen[0], seen[1], seen[2], seen[3]);
    end
    rdy = 1'b0; done = 1'b0;
  endtask

  task automatic test_sticky();
    logic [18:0] e;
    do_reset();
    req = 12'h020;
    tick();
    req = '0;
    for (int c = 0; c < 3; c++) begin
      e = ex(1'b1, 1'b0, 1'b0, 5);
      checks++; if (o_m !== e) begin errors++; $display("FAIL sticky%0d: got %h exp %h", c, o_m, e); end
      tick();
    end
    rdy = 1'b1; done = 1'b1;
    tick();
    rdy = 1'b0; done = 1'b0;
    e = ex(1'b0, 1'b0, 1'b0, -1);
    checks++; if (o_m !== e) begin errors++; $display("FAIL sticky_rel: got %h exp %h", o_m, e); end
  endtask

  task automatic test_busy_hold();
    logic [18:0] e;
    do_reset();
    req = 12'h008;
    tick();
    rdy = 1'b1; req = 12'hFFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      rdy = 1'b0;
      e = ex(1'b0, 1'b1, 1'b0, 3);
      checks++; if (o_m !== e) begin errors++; $display("FAIL busy_hold%0d: got %h exp %h", c, o_m, e); end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    m_last = 3;
    e = ex(1'b0, 1'b0, 1'b0, -1);
    checks++; if (o_m !== e) begin errors++; $display("FAIL busy_rel: got %h exp %h", o_m, e); end
    tick();
    e = ex(1'b1, 1'b0, 1'b0, pick(req, m_last));
    checks++; if (o_m !== e || idx !== 4'd2) begin errors++; $display("FAIL busy_next: got %h exp %h", o_m, e); end
  endtask

  task automatic test_watchdog();
    logic [18:0] e;
    do_reset();
    req = 12'hFFF;
    tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    for (int c = 1; c < TW; c++) begin
      e = ex(1'b0, 1'b1, 1'b0, 11);
      checks++; if (o_w !== e) begin errors++; $display("FAIL wdog_busy%0d: got %h exp %h", c, o_w, e); end
      tick();
    end
    tick();
    e = ex(1'b0, 1'b0, 1'b1, -1);
    checks++; if (o_w !== e) begin errors++; $display("FAIL wdog_pulse: got %h exp %h", o_w, e); end
    tick();
    e = ex(1'b1, 1'b0, 1'b0, pick(req, 11));
    checks++; if (o_w !== e || w_idx !== 4'd10) begin errors++; $display("FAIL wdog_next: got %h exp %h", o_w, e); end
  endtask

  task automatic test_done_on_timeout();
    logic [18:0] e;
    do_reset();
    req = 12'h004;
    tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    for (int c = 1; c < TW; c++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    e = ex(1'b0, 1'b0, 1'b0, -1);
    checks++; if (o_w !== e) begin errors++; $display("FAIL done_tmo: got %h exp %h", o_w, e); end
  endtask

  task automatic test_reset_mid_busy();
    logic [18:0] e;
    do_reset();
    req = 12'hFFF;
    tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    e = ex(1'b0, 1'b1, 1'b0, 11);
    checks++; if (o_m !== e) begin errors++; $display("FAIL rstmid_busy: got %h exp %h", o_m, e); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (o_m !== 19'h0) begin errors++; $display("FAIL rstmid_zero: got %h exp %h", o_m, 19'h0); end
    req = 12'h003;
    tick();
    e = ex(1'b1, 1'b0, 1'b0, 1);
    checks++; if (o_m !== e) begin errors++; $display("FAIL rstmid_next: got %h exp %h", o_m, e); end
  endtask

  task automatic test_random();
    logic [18:0]  e;
    logic [N-1:0] r;
    int cur, d, k;
    bit fin;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      r = 12'($urandom);
      if (r == '0) r = 12'h001;
      req = r;
      tick();
      cur = pick(r, m_last);
      e = ex(1'b1, 1'b0, 1'b0, cur);
      checks++; if (o_w !== e) begin errors++; $display("FAIL rnd_grant%0d: got %h exp %h", t, o_w, e); end
      d = $urandom_range(0, 2);
      for (int j = 0; j < d; j++) begin
        req = 12'($urandom);
        tick();
        checks++; if (o_w !== e) begin errors++; $display("FAIL rnd_wait%0d: got %h exp %h", t, o_w, e); end
      end
      rdy  = 1'b1;
      done = ($urandom_range(0, 2) == 0);
      tick();
      rdy = 1'b0;
      if (done) begin
        done = 1'b0;
        e = ex(1'b0, 1'b0, 1'b0, -1);
        checks++; if (o_w !== e) begin errors++; $display("FAIL rnd_fast%0d: got %h exp %h", t, o_w, e); end
      end else begin
        e = ex(1'b0, 1'b1, 1'b0, cur);
        checks++; if (o_w !== e) begin errors++; $display("FAIL rnd_busy%0d: got %h exp %h", t, o_w, e); end
        k   = $urandom_range(1, 6);
        fin = 1'b0;
        for (int c = 1; c <= TW && !fin; c++) begin
          done = (c == k);
          tick();
          if (c == k) begin
            e = ex(1'b0, 1'b0, 1'b0, -1);
            fin = 1'b1;
          end else if (c == TW) begin
            e = ex(1'b0, 1'b0, 1'b1, -1);
            fin = 1'b1;
          end else begin
            e = ex(1'b0, 1'b1, 1'b0, cur);
          end
          checks++; if (o_w !== e) begin errors++; $display("FAIL rnd_hold%0d_%0d: got %h exp %h", t, c, o_w, e); end
        end
        done = 1'b0;
      end
      m_last = cur;
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_sticky();
    test_busy_hold();
    test_watchdog();
    test_done_on_timeout();
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
